// File: rtl/umi_out_buffer.sv
// Elastic FIFO stage for a single UMI stream. Every handshake output is driven from
// registered state. An optional packet mode holds output until a whole message is buffered.
module umi_out_buffer #(
    parameter int unsigned DW     = 256,
    parameter int unsigned CW     = 32,
    parameter int unsigned AW     = 64,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PACKET = 0
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       umi_in_valid,
    input  logic [CW-1:0]              umi_in_cmd,
    input  logic [AW-1:0]              umi_in_dstaddr,
    input  logic [AW-1:0]              umi_in_srcaddr,
    input  logic [DW-1:0]              umi_in_data,
    output logic                       umi_in_ready,
    output logic                       umi_out_valid,
    output logic [CW-1:0]              umi_out_cmd,
    output logic [AW-1:0]              umi_out_dstaddr,
    output logic [AW-1:0]              umi_out_srcaddr,
    output logic [DW-1:0]              umi_out_data,
    input  logic                       umi_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH+1);
    localparam int unsigned EW   = CW + 2 * AW + DW;

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d, eomcnt_q, eomcnt_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic            draining_q, draining_d;
    logic            wr, rd, in_eom, head_eom;

    assign wr       = umi_in_valid & umi_in_ready;
    assign rd       = umi_out_valid & umi_out_ready;
    assign in_eom   = umi_in_cmd[22];
    assign head     = mem[rptr_q];
    assign head_eom = umi_out_cmd[22];

    // Storage carries no reset; contents while empty are don't-care.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr_q] <= {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            eomcnt_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            draining_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            eomcnt_q   <= eomcnt_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            draining_q <= draining_d;
        end
    end

    always_comb begin
        wptr_d     = wptr_q + PW'(wr);
        rptr_d     = rptr_q + PW'(rd);
        count_d    = count_q;
        eomcnt_d   = eomcnt_q;
        draining_d = draining_q;

        unique case ({wr, rd})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        unique case ({wr & in_eom, rd & head_eom})
            2'b10:   eomcnt_d = eomcnt_q + CNTW'(1);
            2'b01:   eomcnt_d = eomcnt_q - CNTW'(1);
            default: eomcnt_d = eomcnt_q;
        endcase

        // A message keeps draining from its first read until its EOM beat leaves.
        if (rd) begin
            draining_d = ~head_eom;
        end

        full_d  = (count_d == CNTW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_comb begin
        umi_in_ready = ~full_q;
        if (PACKET != 0) begin
            // Full forces release so messages longer than DEPTH cannot deadlock.
            umi_out_valid = ~empty_q & ((eomcnt_q != '0) | full_q | draining_q);
        end else begin
            umi_out_valid = ~empty_q;
        end
    end

    assign umi_out_cmd     = head[EW-1 -: CW];
    assign umi_out_dstaddr = head[EW-CW-1 -: AW];
    assign umi_out_srcaddr = head[EW-CW-AW-1 -: AW];
    assign umi_out_data    = head[DW-1:0];

    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_umi_out_buffer.sv
// Directed and randomized checks of umi_out_buffer in streaming (A) and packet (B) modes.
module tb_umi_out_buffer;

    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int AW    = 64;
    localparam int DEPTH = 4;
    localparam int CNTW  = 3;
    localparam logic [CW-1:0] CMD_EOM  = 32'h0040_0003;
    localparam logic [CW-1:0] CMD_BODY = 32'h0000_0003;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_full, a_empty;
    logic [CW-1:0]   a_in_cmd, a_out_cmd;
    logic [AW-1:0]   a_in_dst, a_in_src, a_out_dst, a_out_src;
    logic [DW-1:0]   a_in_data, a_out_data;
    logic [CNTW-1:0] a_count;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_full, b_empty;
    logic [CW-1:0]   b_in_cmd, b_out_cmd;
    logic [AW-1:0]   b_in_dst, b_in_src, b_out_dst, b_out_src;
    logic [DW-1:0]   b_in_data, b_out_data;
    logic [CNTW-1:0] b_count;

    umi_out_buffer #(.DW(DW), .CW(CW), .AW(AW), .DEPTH(DEPTH), .PACKET(0)) u_dut_a (
        .clk(clk), .nreset(nreset),
        .umi_in_valid(a_in_valid), .umi_in_cmd(a_in_cmd), .umi_in_dstaddr(a_in_dst),
        .umi_in_srcaddr(a_in_src), .umi_in_data(a_in_data), .umi_in_ready(a_in_ready),
        .umi_out_valid(a_out_valid), .umi_out_cmd(a_out_cmd), .umi_out_dstaddr(a_out_dst),
        .umi_out_srcaddr(a_out_src), .umi_out_data(a_out_data), .umi_out_ready(a_out_ready),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    umi_out_buffer #(.DW(DW), .CW(CW), .AW(AW), .DEPTH(DEPTH), .PACKET(1)) u_dut_b (
        .clk(clk), .nreset(nreset),
        .umi_in_valid(b_in_valid), .umi_in_cmd(b_in_cmd), .umi_in_dstaddr(b_in_dst),
        .umi_in_srcaddr(b_in_src), .umi_in_data(b_in_data), .umi_in_ready(b_in_ready),
        .umi_out_valid(b_out_valid), .umi_out_cmd(b_out_cmd), .umi_out_dstaddr(b_out_dst),
        .umi_out_srcaddr(b_out_src), .umi_out_data(b_out_data), .umi_out_ready(b_out_ready),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_data;
        int sent, rcvd, cyc, wi;
        bit hold, overflow, wr, rd, rdy;

        a_in_valid = 0; a_in_cmd = CMD_BODY; a_in_dst = '0; a_in_src = '0; a_in_data = '0;
        a_out_ready = 0;
        b_in_valid = 0; b_in_cmd = CMD_BODY; b_in_dst = '0; b_in_src = '0; b_in_data = '0;
        b_out_ready = 0;

        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_empty", 64'(a_empty), 64'd1);
        check("rst_full", 64'(a_full), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);

        // Single beat latency
        a_out_ready = 1; a_in_valid = 1; a_in_data = 32'hA5;
        step();
        a_in_valid = 0;
        check("single_valid", 64'(a_out_valid), 64'd1);
        check("single_data", 64'(a_out_data), 64'hA5);
        check("single_count", 64'(a_count), 64'd1);
        step();
        check("single_drained", 64'(a_count), 64'd0);
        check("single_empty", 64'(a_empty), 64'd1);

        // Fill, refuse, free one slot, accept the fifth
        a_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = 32'h10 + 32'(i);
            step();
        end
        a_in_data = 32'h14;
        check("fill_full", 64'(a_full), 64'd1);
        check("fill_in_ready", 64'(a_in_ready), 64'd0);
        check("fill_count", 64'(a_count), 64'd4);
        step();
        check("refused_count", 64'(a_count), 64'd4);
        a_out_ready = 1;
        step();
        check("free_count", 64'(a_count), 64'd3);
        check("free_in_ready", 64'(a_in_ready), 64'd1);
        check("free_head", 64'(a_out_data), 64'h11);
        a_out_ready = 0;
        step();
        a_in_valid = 0;
        check("fifth_count", 64'(a_count), 64'd4);
        a_out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            check("order_valid", 64'(a_out_valid), 64'd1);
            check("order_data", 64'(a_out_data), 64'h10 + 64'(k));
            step();
        end
        check("order_empty", 64'(a_empty), 64'd1);

        // Random streaming with valid/ready toggling
        sent = 0; rcvd = 0; cyc = 0; hold = 0; overflow = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            if (!hold) begin
                if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                    a_in_valid = 1; a_in_data = $urandom; a_in_cmd = $urandom;
                    a_in_dst = {a_in_data, ~a_in_data};
                end else begin
                    a_in_valid = 0;
                end
            end
            a_out_ready = 1'($urandom_range(0, 1));
            if (a_count > 3'(DEPTH)) overflow = 1;
            wr = a_in_valid & a_in_ready;
            rd = a_out_valid & a_out_ready;
            if (rd) begin
                exp_data = (q.size() > 0) ? q.pop_front() : 'x;
                check("rand_order", 64'(a_out_data), 64'(exp_data));
                rcvd++;
            end
            if (wr) begin
                q.push_back(a_in_data);
                sent++;
            end
            hold = a_in_valid & ~wr;
            step();
            cyc++;
        end
        a_in_valid = 0; a_in_cmd = CMD_BODY;
        check("rand_received", 64'(rcvd), 64'd1000);
        check("rand_no_overflow", 64'(overflow), 64'd0);

        // Packet mode: 3-beat message with stalls
        b_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1; b_in_data = 32'h30 + 32'(i);
            b_in_cmd = (i == 2) ? CMD_EOM : CMD_BODY;
            step();
            b_in_valid = 0;
            if (i < 2) begin
                check("pkt_withheld", 64'(b_out_valid), 64'd0);
                step();
                check("pkt_withheld_stall", 64'(b_out_valid), 64'd0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            check("pkt_valid", 64'(b_out_valid), 64'd1);
            check("pkt_data", 64'(b_out_data), 64'h30 + 64'(k));
            step();
        end
        check("pkt_done", 64'(b_out_valid), 64'd0);

        // Packet mode: 6-beat message, released by full
        b_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1; b_in_data = 32'h40 + 32'(i); b_in_cmd = CMD_BODY;
            step();
            if (i == 2) check("long_withheld", 64'(b_out_valid), 64'd0);
        end
        b_in_valid = 0;
        check("long_full", 64'(b_full), 64'd1);
        b_out_ready = 1;
        wi = 4;
        for (int k = 0; k < 6; k++) begin
            check("long_valid", 64'(b_out_valid), 64'd1);
            check("long_data", 64'(b_out_data), 64'h40 + 64'(k));
            if (wi < 6) begin
                b_in_valid = 1; b_in_data = 32'h40 + 32'(wi);
                b_in_cmd = (wi == 5) ? CMD_EOM : CMD_BODY;
            end else begin
                b_in_valid = 0;
            end
            rdy = b_in_ready;
            step();
            if (b_in_valid && rdy) wi++;
        end
        b_in_valid = 0;
        check("long_empty", 64'(b_empty), 64'd1);
        // A lone non-EOM beat must be held again once draining has cleared
        b_in_valid = 1; b_in_data = 32'h55; b_in_cmd = CMD_BODY;
        step();
        b_in_valid = 0;
        step();
        check("long_drain_cleared", 64'(b_out_valid), 64'd0);
        check("long_lone_count", 64'(b_count), 64'd1);

        // Asynchronous reset mid-stream
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1; a_in_data = 32'h60 + 32'(i);
            step();
        end
        a_in_valid = 0;
        check("pre_rst_count", 64'(a_count), 64'd3);
        #2 nreset = 1'b0;
        #1;
        check("arst_count", 64'(a_count), 64'd0);
        check("arst_empty", 64'(a_empty), 64'd1);
        check("arst_out_valid", 64'(a_out_valid), 64'd0);
        check("arst_b_count", 64'(b_count), 64'd0);
        step();
        nreset = 1'b1;
        a_in_valid = 1; a_in_data = 32'h77; a_out_ready = 1;
        step();
        a_in_valid = 0;
        check("post_rst_valid", 64'(a_out_valid), 64'd1);
        check("post_rst_data", 64'(a_out_data), 64'h77);
        step();
        check("post_rst_empty", 64'(a_empty), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
